// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, drives IMEM reads, tracks the PC_ID/InstrValid pair.
// Optional MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        Resume,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] PC,
    output logic        MemRead,
    output logic [31:0] PC_ID,
    output logic        InstrValid,
    output logic [31:0] InstrCount,
    output logic        MisalignTrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state;
    logic        redirect;
    logic        misalign;
    logic [31:0] tgt;
    logic [31:0] next_tgt;

    assign MemRead  = (state == S_RUN) && !Stall && !Halt;
    assign redirect = (state != S_IDLE) && (Jump || BranchTaken);
    assign tgt      = Jump ? JumpTarget : BranchTarget;

`ifdef MISALIGN_TRAP_EN
    assign misalign = |tgt[1:0];
`else
    logic unused_tgt_bits;
    assign misalign        = 1'b0;
    assign unused_tgt_bits = ^tgt[1:0];
`endif

    assign next_tgt = misalign ? TRAP_VECTOR : {tgt[31:2], 2'b00};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            PC           <= RESET_VECTOR;
            PC_ID        <= RESET_VECTOR;
            InstrValid   <= 1'b0;
            InstrCount   <= 32'd0;
            MisalignTrap <= 1'b0;
        end else begin
            MisalignTrap <= redirect && misalign;
            if (MemRead && InstrValid)
                InstrCount <= InstrCount + 32'd1;
            // The fetch issued alongside a redirect is wrong-path
            if (redirect) begin
                PC         <= next_tgt;
                InstrValid <= 1'b0;
                if (MemRead)
                    PC_ID <= PC;
            end else if (MemRead) begin
                PC         <= PC + 32'd4;
                PC_ID      <= PC;
                InstrValid <= 1'b1;
            end
            unique case (state)
                S_IDLE:  state <= S_RUN;
                S_RUN:   if (Halt) state <= S_HALT;
                S_HALT:  if (Resume) state <= S_RUN;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized bench for fetch_pc_unit against a behavioural model.
// Honours MISALIGN_TRAP_EN when the bench is built with it.
module tb_fetch_pc_unit;

    logic        CLK;
    logic        RST;
    logic        Stall;
    logic        Halt;
    logic        Resume;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] PC;
    logic        MemRead;
    logic [31:0] PC_ID;
    logic        InstrValid;
    logic [31:0] InstrCount;
    logic        MisalignTrap;

    int total;
    int passed;
    int fails;

    bit          m_started;
    bit          m_halted;
    bit          m_iv;
    bit          m_trap;
    logic [31:0] m_pc;
    logic [31:0] m_pcid;
    logic [31:0] m_cnt;

    fetch_pc_unit dut (
        .CLK(CLK),
        .RST(RST),
        .Stall(Stall),
        .Halt(Halt),
        .Resume(Resume),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpTarget(JumpTarget),
        .PC(PC),
        .MemRead(MemRead),
        .PC_ID(PC_ID),
        .InstrValid(InstrValid),
        .InstrCount(InstrCount),
        .MisalignTrap(MisalignTrap)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_mr();
        return m_started && !m_halted && !Stall && !Halt;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".PC"}, PC, m_pc);
        chk({tag, ".PC_ID"}, PC_ID, m_pcid);
        chk({tag, ".InstrValid"}, {31'd0, InstrValid}, {31'd0, m_iv});
        chk({tag, ".InstrCount"}, InstrCount, m_cnt);
        chk({tag, ".MemRead"}, {31'd0, MemRead}, {31'd0, model_mr()});
        chk({tag, ".MisalignTrap"}, {31'd0, MisalignTrap}, {31'd0, m_trap});
    endtask

    task automatic model_reset;
        m_started = 0;
        m_halted  = 0;
        m_iv      = 0;
        m_trap    = 0;
        m_pc      = 32'h0;
        m_pcid    = 32'h0;
        m_cnt     = 32'h0;
    endtask

    // Inputs are still the pre-edge values when this runs
    task automatic model_edge(input bit mr);
        logic [31:0] t;
        bit          mis;
        if (!m_started) begin
            m_started = 1;
        end else begin
            t   = Jump ? JumpTarget : BranchTarget;
            mis = 0;
`ifdef MISALIGN_TRAP_EN
            mis = (t % 4) != 0;
`endif
            if (mr && m_iv)
                m_cnt = m_cnt + 1;
            m_trap = 0;
            if (Jump || BranchTaken) begin
                if (mr)
                    m_pcid = m_pc;
                m_iv   = 0;
                m_trap = mis;
                m_pc   = mis ? 32'h100 : t - (t % 4);
            end else if (mr) begin
                m_pcid = m_pc;
                m_pc   = m_pc + 4;
                m_iv   = 1;
            end
            if (m_halted)
                m_halted = !Resume;
            else
                m_halted = Halt;
        end
    endtask

    task automatic step(input string tag, input bit st, input bit hl,
                        input bit rs, input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt);
        bit mr;
        Stall        = st;
        Halt         = hl;
        Resume       = rs;
        BranchTaken  = br;
        BranchTarget = bt;
        Jump         = jp;
        JumpTarget   = jt;
        @(negedge CLK);
        check_all(tag);
        mr = model_mr();
        @(posedge CLK);
        model_edge(mr);
        #1;
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic do_reset;
        Stall        = 0;
        Halt         = 0;
        Resume       = 0;
        BranchTaken  = 0;
        BranchTarget = 0;
        Jump         = 0;
        JumpTarget   = 0;
        RST          = 1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge CLK);
        #1;
        RST = 0;
    endtask

    initial begin
        logic [31:0] exp_trap_pc;
        logic [31:0] exp_trap;
        total  = 0;
        passed = 0;
        fails  = 0;
        RST    = 0;
        Stall  = 0;
        Halt   = 0;
        Resume = 0;
        BranchTaken  = 0;
        BranchTarget = 0;
        Jump         = 0;
        JumpTarget   = 0;
        #2;
        do_reset();

        // Reset release and free run
        chk("t1.idle_memread", {31'd0, MemRead}, 32'd0);
        idle_steps("t1", 6);
        chk("t1.pc", PC, 32'h14);
        chk("t1.count", InstrCount, 32'd4);

        // Stall at 0x10
        do_reset();
        idle_steps("t2a", 5);
        chk("t2.pc_before", PC, 32'h10);
        for (int i = 0; i < 3; i++)
            step("t2s", 1, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("t2.pc_held", PC, 32'h10);
        chk("t2.pcid_held", PC_ID, 32'hC);
        chk("t2.count_held", InstrCount, 32'd3);
        idle_steps("t2b", 1);
        chk("t2.pc_resumed", PC, 32'h14);

        // Branch from 0x08
        do_reset();
        idle_steps("t3a", 3);
        chk("t3.pc_before", PC, 32'h08);
        step("t3br", 0, 0, 0, 1, 32'h40, 0, 32'h0);
        chk("t3.pc_target", PC, 32'h40);
        chk("t3.squash", {31'd0, InstrValid}, 32'd0);
        idle_steps("t3b", 1);
        chk("t3.pcid_target", PC_ID, 32'h40);
        chk("t3.valid_target", {31'd0, InstrValid}, 32'd1);

        // Jump beats branch and stall
        do_reset();
        idle_steps("t4a", 2);
        step("t4j", 1, 0, 0, 1, 32'h40, 1, 32'h80);
        chk("t4.pc_jump", PC, 32'h80);
        idle_steps("t4b", 2);

        // Halt at 0x20
        do_reset();
        idle_steps("t5a", 9);
        chk("t5.pc_before", PC, 32'h20);
        step("t5h", 0, 1, 0, 0, 32'h0, 0, 32'h0);
        idle_steps("t5w", 5);
        chk("t5.pc_frozen", PC, 32'h20);
        chk("t5.halt_memread", {31'd0, MemRead}, 32'd0);
        step("t5r", 0, 0, 1, 0, 32'h0, 0, 32'h0);
        idle_steps("t5b", 1);
        chk("t5.pcid_resume", PC_ID, 32'h20);
        chk("t5.pc_resume", PC, 32'h24);

        // Wrap, misaligned target, reset mid-redirect
        do_reset();
        idle_steps("t6a", 2);
        step("t6wrap", 0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        chk("t6.pc_top", PC, 32'hFFFF_FFFC);
        idle_steps("t6b", 1);
        chk("t6.pc_wrapped", PC, 32'h0);
`ifdef MISALIGN_TRAP_EN
        exp_trap_pc = 32'h100;
        exp_trap    = 32'd1;
`else
        exp_trap_pc = 32'h40;
        exp_trap    = 32'd0;
`endif
        step("t6mis", 0, 0, 0, 0, 32'h0, 1, 32'h42);
        chk("t6.pc_mis", PC, exp_trap_pc);
        chk("t6.trap", {31'd0, MisalignTrap}, exp_trap);
        idle_steps("t6c", 1);
        chk("t6.trap_pulse", {31'd0, MisalignTrap}, 32'd0);
        step("t6rd", 0, 0, 0, 1, 32'h60, 0, 32'h0);
        RST = 1;
        #1;
        chk("t6.rst_pc", PC, 32'h0);
        chk("t6.rst_pcid", PC_ID, 32'h0);
        chk("t6.rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("t6.rst_count", InstrCount, 32'd0);
        chk("t6.rst_memread", {31'd0, MemRead}, 32'd0);
        chk("t6.rst_trap", {31'd0, MisalignTrap}, 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt;
            logic [31:0] jt;
            bt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                             : {20'd0, 12'($urandom)};
            jt = $urandom;
            step("rand",
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 10, bt,
                 $urandom_range(0, 99) < 6, jt);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
